// File: rtl/fp_mul_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_arb_pkg
//  Purpose  : Shared types and constants for the FP multiplier arbiter.
//             State encoding of the arbiter FSM and the quiet-NaN value
//             returned on a multiplier timeout.
//  Revision : 1.0 - initial release
// ============================================================================
package fp_mul_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // IEEE-754 single-precision quiet NaN, returned when the multiplier hangs
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage : fp_mul_arb_pkg
`default_nettype wire

// File: rtl/fp_mul_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_arbiter_if
//  Purpose  : Bundles the requester-side bus and the shared-multiplier
//             handshake of the FP multiplier arbiter.
//             slave  : arbiter view
//             master : requesters + multiplier view
//             The err signal exists only when FP_MUL_ARB_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface fp_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    // Requester side
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] reqA;
    logic [NREQ*W-1:0] reqB;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      result;
    logic              busy;
    // Multiplier side
    logic              startMul;
    logic [W-1:0]      mulA;
    logic [W-1:0]      mulB;
    logic [W-1:0]      mulResult;
    logic              doneMul;
`ifdef FP_MUL_ARB_TIMEOUT_EN
    logic              err;
`endif

    modport slave (
        input  req, reqA, reqB, mulResult, doneMul,
        output ack, result, busy, startMul, mulA, mulB
`ifdef FP_MUL_ARB_TIMEOUT_EN
        , output err
`endif
    );

    modport master (
        output req, reqA, reqB, mulResult, doneMul,
        input  ack, result, busy, startMul, mulA, mulB
`ifdef FP_MUL_ARB_TIMEOUT_EN
        , input err
`endif
    );

endinterface : fp_mul_arbiter_if
`default_nettype wire

// File: rtl/fp_mul_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin selector. Searches req starting at
//             ptr+1 and wrapping modulo NREQ; reports the first set bit.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  wire logic [NREQ-1:0] req_i,
    input  wire logic [IDXW-1:0] ptr_i,
    output logic                 grant_valid_o,
    output logic [IDXW-1:0]      grant_idx_o
);

    // Walk offsets from farthest to nearest so the nearest set bit wins last
    always_comb begin
        int cand;
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(ptr_i) + k) % NREQ;
            if (req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = IDXW'(cand);
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_arbiter
//  Purpose  : Shares one FP multiplier among NREQ requesters. Round-robin
//             grant, startMul/doneMul sequencing, one-cycle ack with the
//             product broadcast on result.
//  Options  : FP_MUL_ARB_TIMEOUT_EN - adds a WAIT-state timeout counter; on
//             expiry the requester is acked with a qNaN and sticky err is set.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fp_mul_arbiter_if.slave   bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Parameter sanity: NREQ 2..8, TIMEOUT must fit the 8-bit counter
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("fp_mul_arbiter: parameter out of range");
    end

    arb_state_t      state_q, state_d;
    logic [IDXW-1:0] ptr_q,   ptr_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic [W-1:0]    opa_q,   opa_d;
    logic [W-1:0]    opb_q,   opb_d;
    logic [W-1:0]    res_q,   res_d;

    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;

`ifdef FP_MUL_ARB_TIMEOUT_EN
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req_i         (bus.req),
        .ptr_i         (ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDXW'(NREQ - 1);
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
`ifdef FP_MUL_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
`ifdef FP_MUL_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic: grant, issue, wait for completion, respond
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
`ifdef FP_MUL_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    idx_d   = grant_idx;
                    opa_d   = bus.reqA[int'(grant_idx)*W +: W];
                    opb_d   = bus.reqB[int'(grant_idx)*W +: W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef FP_MUL_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.doneMul) begin
                    res_d   = bus.mulResult;
                    state_d = RESP;
                end
`ifdef FP_MUL_ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Multiplier never answered: hand back a qNaN and flag it
                    res_d   = W'(QNAN);
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                // Winner becomes lowest priority for the next search
                ptr_d   = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        bus.ack      = '0;
        if (state_q == RESP) begin
            bus.ack[idx_q] = 1'b1;
        end
        bus.busy     = (state_q != IDLE);
        bus.startMul = (state_q == ISSUE);
        bus.mulA     = opa_q;
        bus.mulB     = opb_q;
        bus.result   = res_q;
`ifdef FP_MUL_ARB_TIMEOUT_EN
        bus.err      = err_q;
`endif
    end

endmodule : fp_mul_arbiter
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_arbiter
//  Purpose  : Directed self-checking bench for fp_mul_arbiter with a
//             multiplier model answering 4 cycles after startMul.
//  Options  : FP_MUL_ARB_TIMEOUT_EN enables the timeout scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_arbiter;
    import fp_mul_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Multiplier model state
    logic        mdl_en;
    logic        mdl_done;
    logic [31:0] mdl_res;
    int          mdl_cnt;
    logic        man_done;

    // Operand / product table (hand computed)
    logic [31:0] opA   [NREQ];
    logic [31:0] opB   [NREQ];
    logic [31:0] prod  [NREQ];

    fp_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus_if ();

    fp_mul_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    assign bus_if.doneMul   = mdl_done | man_done;
    assign bus_if.mulResult = mdl_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3FC00000, 32'h40000000}: return 32'h40400000; // 1.5 * 2.0
            {32'h40000000, 32'h40400000}: return 32'h40C00000; // 2.0 * 3.0
            {32'h3F000000, 32'h40800000}: return 32'h40000000; // 0.5 * 4.0
            {32'hBF800000, 32'h40000000}: return 32'hC0000000; // -1.0 * 2.0
            default:                      return 32'h0BADF00D;
        endcase
    endfunction

    // Multiplier model: doneMul one cycle, 4 cycles after startMul
    always @(negedge clk) begin
        if (rst || !mdl_en) begin
            mdl_cnt  = 0;
            mdl_done = 1'b0;
        end else if (bus_if.startMul) begin
            mdl_cnt  = 4;
            mdl_done = 1'b0;
            mdl_res  = fmul_ref(bus_if.mulA, bus_if.mulB);
        end else if (mdl_cnt != 0) begin
            mdl_cnt  = mdl_cnt - 1;
            mdl_done = (mdl_cnt == 0);
        end else begin
            mdl_done = 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        bus_if.req = '0;
        man_done   = 1'b0;
        mdl_en     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a nonzero ack; records operands at startMul and busy-low cycles
    task automatic wait_ack(input int maxc, output logic [3:0] got, output int cyc,
                            output logic [31:0] sa, output logic [31:0] sb, output int idle_cnt);
        got = '0; cyc = 0; sa = '0; sb = '0; idle_cnt = 0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (bus_if.startMul) begin
                sa = bus_if.mulA;
                sb = bus_if.mulB;
            end
            if (!bus_if.busy) idle_cnt++;
            if (bus_if.ack != '0) begin
                got = bus_if.ack;
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus_if.ack, bus_if.busy, bus_if.startMul} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack/busy/start=%b required 0", {bus_if.ack, bus_if.busy, bus_if.startMul});
        end
        n_checks++;
        if ({bus_if.result, bus_if.mulA, bus_if.mulB} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h mulA=%h mulB=%h required 0", bus_if.result, bus_if.mulA, bus_if.mulB);
        end
    endtask

    task automatic test_single();
        logic [3:0]  got;
        logic [31:0] sa, sb;
        int          cyc, idle;
        apply_reset();
        bus_if.req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (bus_if.startMul !== 1'b1 || bus_if.mulA !== 32'h3FC00000 || bus_if.mulB !== 32'h40000000) begin
            n_fail++;
            $display("FAIL single_issue: start=%b A=%h B=%h required 1 3fc00000 40000000", bus_if.startMul, bus_if.mulA, bus_if.mulB);
        end
        wait_ack(20, got, cyc, sa, sb, idle);
        n_checks++;
        if (got !== 4'b0001 || cyc !== 5) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b at cycle %0d required 0001 at 6", got, cyc + 1);
        end
        n_checks++;
        if (bus_if.result !== 32'h40400000) begin
            n_fail++;
            $display("FAIL single_result: %h required 40400000", bus_if.result);
        end
        bus_if.req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (bus_if.ack !== 4'b0000 || bus_if.busy !== 1'b0 || bus_if.result !== 32'h40400000) begin
            n_fail++;
            $display("FAIL single_after: ack=%b busy=%b result=%h required 0000 0 40400000", bus_if.ack, bus_if.busy, bus_if.result);
        end
    endtask

    task automatic test_two_req();
        logic [3:0]  got;
        logic [31:0] sa, sb;
        int          cyc, idle;
        apply_reset();
        bus_if.req = 4'b0110;
        wait_ack(20, got, cyc, sa, sb, idle);
        n_checks++;
        if (got !== 4'b0010 || sa !== 32'h40000000 || sb !== 32'h40400000 || bus_if.result !== 32'h40C00000) begin
            n_fail++;
            $display("FAIL two_first: ack=%b A=%h B=%h res=%h required 0010 40000000 40400000 40c00000", got, sa, sb, bus_if.result);
        end
        bus_if.req = 4'b0100;
        wait_ack(20, got, cyc, sa, sb, idle);
        n_checks++;
        if (got !== 4'b0100 || sa !== 32'h3F000000 || sb !== 32'h40800000 || bus_if.result !== 32'h40000000) begin
            n_fail++;
            $display("FAIL two_second: ack=%b A=%h B=%h res=%h required 0100 3f000000 40800000 40000000", got, sa, sb, bus_if.result);
        end
        bus_if.req = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  got;
        logic [31:0] sa, sb;
        int          cyc, idle;
        int          exp_i;
        apply_reset();
        bus_if.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_i = g % NREQ;
            wait_ack(20, got, cyc, sa, sb, idle);
            n_checks++;
            if (got !== 4'(1 << exp_i) || bus_if.result !== prod[exp_i] || idle !== 0 || cyc !== 6) begin
                n_fail++;
                $display("FAIL rr_grant%0d: ack=%b res=%h idle=%0d cyc=%0d required %b %h 0 6",
                         g, got, bus_if.result, idle, cyc, 4'(1 << exp_i), prod[exp_i]);
            end
            bus_if.req[exp_i] = 1'b0;
            @(negedge clk);
            n_checks++;
            if (bus_if.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: busy=%b required 0", g, bus_if.busy);
            end
            bus_if.req[exp_i] = 1'b1;
        end
        bus_if.req = 4'b0000;
    endtask

    task automatic test_drop_in_issue();
        logic [3:0]  got;
        logic [31:0] sa, sb;
        int          cyc, idle;
        apply_reset();
        bus_if.req = 4'b1000;
        @(negedge clk);
        bus_if.req = 4'b0000;
        wait_ack(20, got, cyc, sa, sb, idle);
        n_checks++;
        if (got !== 4'b1000 || bus_if.result !== 32'hC0000000) begin
            n_fail++;
            $display("FAIL drop_issue: ack=%b res=%h required 1000 c0000000", got, bus_if.result);
        end
    endtask

    task automatic test_reset_in_wait();
        int acks;
        apply_reset();
        mdl_en     = 1'b0;
        bus_if.req = 4'b0001;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut.state_q !== WAIT) begin
            n_fail++;
            $display("FAIL rst_pre: state=%0d required %0d", dut.state_q, WAIT);
        end
        bus_if.req = 4'b0000;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut.state_q !== IDLE || bus_if.busy !== 1'b0 || bus_if.startMul !== 1'b0 ||
            bus_if.ack !== 4'b0 || bus_if.mulA !== 32'd0 || bus_if.result !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async: state=%0d busy=%b start=%b ack=%b mulA=%h res=%h required IDLE all 0",
                     dut.state_q, bus_if.busy, bus_if.startMul, bus_if.ack, bus_if.mulA, bus_if.result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_if.ack !== 4'b0 || bus_if.busy !== 1'b0) acks++;
        end
        n_checks++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL rst_late_done: %0d active cycles required 0", acks);
        end
        mdl_en = 1'b1;
    endtask

`ifdef FP_MUL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0]  got;
        logic [31:0] sa, sb;
        int          cyc, idle;
        apply_reset();
        mdl_en     = 1'b0;
        bus_if.req = 4'b0100;
        wait_ack(30, got, cyc, sa, sb, idle);
        n_checks++;
        if (got !== 4'b0100 || cyc !== 10 || bus_if.result !== 32'h7FC00000 || bus_if.err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_ack: ack=%b cyc=%0d res=%h err=%b required 0100 10 7fc00000 1",
                     got, cyc, bus_if.result, bus_if.err);
        end
        bus_if.req = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_if.err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b required 1", bus_if.err);
        end
        mdl_en = 1'b1;
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        mdl_en      = 1'b1;
        man_done    = 1'b0;
        mdl_res     = '0;
        opA[0] = 32'h3FC00000; opB[0] = 32'h40000000; prod[0] = 32'h40400000;
        opA[1] = 32'h40000000; opB[1] = 32'h40400000; prod[1] = 32'h40C00000;
        opA[2] = 32'h3F000000; opB[2] = 32'h40800000; prod[2] = 32'h40000000;
        opA[3] = 32'hBF800000; opB[3] = 32'h40000000; prod[3] = 32'hC0000000;
        bus_if.req  = '0;
        bus_if.reqA = {opA[3], opA[2], opA[1], opA[0]};
        bus_if.reqB = {opB[3], opB[2], opB[1], opB[0]};

        test_reset();
        test_single();
        test_two_req();
        test_back_to_back();
        test_drop_in_issue();
        test_reset_in_wait();
`ifdef FP_MUL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_fp_mul_arbiter
`default_nettype wire
